// File: rtl/stream_logical_reducer_pkg.sv
// logical_pkg: operator codes, reducer states and the shared operator evaluation function.
// Shared by stream_logical_reducer and logical_op_core.
package logical_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        LOP_AND,
        LOP_OR,
        LOP_XOR,
        LOP_NAND,
        LOP_NOR,
        LOP_XNOR
    } logical_op_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_e;

    // Codes 6 and 7 have no operator of their own and fall back to AND.
    function automatic logic apply_lop(input logic [OP_W-1:0] op, input logic a, input logic b);
        logic r;
        case (op)
            LOP_OR:   r = a | b;
            LOP_XOR:  r = a ^ b;
            LOP_NAND: r = ~(a & b);
            LOP_NOR:  r = ~(a | b);
            LOP_XNOR: r = ~(a ^ b);
            default:  r = a & b;
        endcase
        return r;
    endfunction

    function automatic logic op_illegal(input logic [OP_W-1:0] op);
        return op > OP_W'(LOP_XNOR);
    endfunction

endpackage

// File: rtl/logical_op_core.sv
// logical_op_core: combinational c = op(a, b) for the Logical unit.
module logical_op_core
    import logical_pkg::*;
(
    input  logic            a,
    input  logic            b,
    input  logic [OP_W-1:0] op,
    output logic            c
);

    assign c = apply_lop(op, a, b);

endmodule

// File: rtl/stream_logical_reducer.sv
// stream_logical_reducer: folds streamed operand beats into any-bit-set flags and emits op(A,B) per packet.
// Define LOGICAL_OP_CHECK_EN to add out_err (illegal or changing operator within a packet).
module stream_logical_reducer
    import logical_pkg::*;
#(
    parameter  int N         = 8,
    parameter  int MAX_BEATS = 16,
    localparam int CW        = $clog2(MAX_BEATS + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_a,
    input  logic [N-1:0]    in_b,
    input  logic [OP_W-1:0] in_op,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_c,
`ifdef LOGICAL_OP_CHECK_EN
    output logic            out_err,
`endif
    output logic [CW-1:0]   out_beats
);

    state_e          state;
    logic            acc_a;
    logic            acc_b;
    logic [OP_W-1:0] op_q;
    logic [CW-1:0]   cnt;

    logic            fire;
    logic            first;
    logic [OP_W-1:0] op_eff;
    logic            a_nxt;
    logic            b_nxt;
    logic [CW-1:0]   cnt_nxt;
    logic            c_nxt;

    assign in_ready = !out_valid | out_ready;
    assign fire     = in_valid & in_ready;
    assign first    = state == IDLE;
    assign op_eff   = first ? in_op : op_q;
    assign a_nxt    = acc_a | (|in_a);
    assign b_nxt    = acc_b | (|in_b);
    assign cnt_nxt  = (cnt == CW'(MAX_BEATS)) ? cnt : cnt + 1'b1;

    // The last beat's own data joins the flags before evaluation, so a single-beat packet works.
    logical_op_core u_core (
        .a  (a_nxt),
        .b  (b_nxt),
        .op (op_eff),
        .c  (c_nxt)
    );

`ifdef LOGICAL_OP_CHECK_EN
    logic err_q;
    logic err_nxt;

    assign err_nxt = first ? op_illegal(in_op) : (err_q | (in_op != op_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q   <= 1'b0;
            out_err <= 1'b0;
        end else if (fire) begin
            err_q <= in_last ? 1'b0 : err_nxt;
            if (in_last)
                out_err <= err_nxt;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc_a     <= 1'b0;
            acc_b     <= 1'b0;
            op_q      <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_c     <= 1'b0;
            out_beats <= '0;
        end else begin
            if (fire && in_last) begin
                state     <= IDLE;
                acc_a     <= 1'b0;
                acc_b     <= 1'b0;
                cnt       <= '0;
                out_valid <= 1'b1;
                out_c     <= c_nxt;
                out_beats <= cnt_nxt;
            end else begin
                if (fire) begin
                    state <= ACCUM;
                    acc_a <= a_nxt;
                    acc_b <= b_nxt;
                    cnt   <= cnt_nxt;
                    if (first)
                        op_q <= in_op;
                end
                if (out_ready)
                    out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_logical_reducer.sv
// tb_stream_logical_reducer: randomized and directed checks of stream_logical_reducer against a packet-level model.
// out_err checks are compiled in when LOGICAL_OP_CHECK_EN is defined.
module tb_stream_logical_reducer;

    localparam int N  = 8;
    localparam int MB = 16;
    localparam int CW = $clog2(MB + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  in_a = '0;
    logic [N-1:0]  in_b = '0;
    logic [2:0]    in_op = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_c;
    logic [CW-1:0] out_beats;
`ifdef LOGICAL_OP_CHECK_EN
    logic          out_err;
`endif

    int tests = 0;
    int fails = 0;

    logic [N-1:0] pa [64];
    logic [N-1:0] pb [64];
    logic [2:0]   po [64];

    always #5 clk = ~clk;

    stream_logical_reducer #(.N(N), .MAX_BEATS(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
`ifdef LOGICAL_OP_CHECK_EN
        .out_err   (out_err),
`endif
        .out_beats (out_beats)
    );

    // Packet-level reference: any-bit flags over all beats, operator from beat 0.
    function automatic logic model_c(input int n);
        bit a = 0, b = 0, r;
        int k;
        logic [2:0] op = po[0];
        for (int i = 0; i < n; i++) begin
            a |= pa[i] != 0;
            b |= pb[i] != 0;
        end
        k = (op > 5) ? 0 : int'(op) % 3;
        r = (k == 0) ? (a && b) : (k == 1) ? (a || b) : (a != b);
        return (op >= 3 && op <= 5) ? !r : r;
    endfunction

    function automatic logic [CW-1:0] model_beats(input int n);
        return CW'(n > MB ? MB : n);
    endfunction

    function automatic logic model_err(input int n);
        if (po[0] > 5) return 1'b1;
        for (int i = 1; i < n; i++)
            if (po[i] != po[0]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic fill(input int n, input logic [2:0] op);
        for (int i = 0; i < n; i++) begin
            pa[i] = '0;
            pb[i] = '0;
            po[i] = op;
        end
    endtask

    task automatic send_pkt(input int n);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            in_valid = 1'b1;
            in_a     = pa[i];
            in_b     = pb[i];
            in_op    = po[i];
            in_last  = (i == n - 1);
            while (!in_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                tests++; fails++;
                $display("FAIL send_timeout: in_ready stuck at %0b on beat %0d, required 1", in_ready, i);
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        tests++; if (out_c !== 1'b0) begin fails++; $display("FAIL reset_c: got %0b want 0", out_c); end
        tests++; if (out_beats !== '0) begin fails++; $display("FAIL reset_beats: got %0d want 0", out_beats); end
`ifdef LOGICAL_OP_CHECK_EN
        tests++; if (out_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %0b want 0", out_err); end
`endif
        rst = 1'b0;
        fill(1, 3'd1);
        pa[0] = 8'h01;
        send_pkt(1);
        in_valid = 1'b1; in_a = 8'hff; in_b = 8'hff; in_op = 3'd1; in_last = 1'b0;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %0b want 0", out_valid); end
        tests++; if (out_c !== 1'b0) begin fails++; $display("FAIL midrst_c: got %0b want 0", out_c); end
        tests++; if (out_beats !== '0) begin fails++; $display("FAIL midrst_beats: got %0d want 0", out_beats); end
        fill(1, 3'd1);
        send_pkt(1);
        tests++; if (out_c !== 1'b0) begin fails++; $display("FAIL postrst_c: got %0b want 0", out_c); end
        tests++; if (out_beats !== CW'(1)) begin fails++; $display("FAIL postrst_beats: got %0d want 1", out_beats); end
        @(negedge clk);
    endtask

    task automatic test_single();
        fill(1, 3'd1);
        pb[0] = 8'h10;
        send_pkt(1);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %0b want 1", out_valid); end
        tests++; if (out_c !== 1'b1) begin fails++; $display("FAIL single_c: got %0b want 1", out_c); end
        tests++; if (out_beats !== CW'(1)) begin fails++; $display("FAIL single_beats: got %0d want 1", out_beats); end
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_drop: got %0b want 0", out_valid); end
    endtask

    task automatic test_multi();
        fill(3, 3'd0);
        pa[1] = 8'h04;
        send_pkt(3);
        tests++; if (out_c !== 1'b0) begin fails++; $display("FAIL and3_c: got %0b want 0", out_c); end
        fill(3, 3'd3);
        pa[1] = 8'h04;
        send_pkt(3);
        tests++; if (out_c !== 1'b1) begin fails++; $display("FAIL nand3_c: got %0b want 1", out_c); end
        tests++; if (out_beats !== CW'(3)) begin fails++; $display("FAIL nand3_beats: got %0d want 3", out_beats); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        fill(2, 3'd2);
        pa[0] = 8'h01;
        send_pkt(2);
        in_valid = 1'b1; in_a = 8'hff; in_b = 8'hff; in_op = 3'd1; in_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready[%0d]: got %0b want 0", i, in_ready); end
            tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d]: got %0b want 1", i, out_valid); end
            tests++; if (out_c !== 1'b1) begin fails++; $display("FAIL bp_c[%0d]: got %0b want 1", i, out_c); end
            tests++; if (out_beats !== CW'(2)) begin fails++; $display("FAIL bp_beats[%0d]: got %0d want 2", i, out_beats); end
            @(negedge clk);
        end
        in_a = '0; in_b = '0; in_op = 3'd0; in_last = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid: got %0b want 1", out_valid); end
        tests++; if (out_c !== 1'b0) begin fails++; $display("FAIL b2b_c: got %0b want 0", out_c); end
        tests++; if (out_beats !== CW'(1)) begin fails++; $display("FAIL b2b_beats: got %0d want 1", out_beats); end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        fill(19, 3'd2);
        pa[17] = 8'h20;
        send_pkt(19);
        tests++; if (out_c !== model_c(19)) begin fails++; $display("FAIL sat_c: got %0b want %0b", out_c, model_c(19)); end
        tests++; if (out_beats !== model_beats(19)) begin fails++; $display("FAIL sat_beats: got %0d want %0d", out_beats, model_beats(19)); end
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int p = 0; p < 25; p++) begin
            int n = $urandom_range(1, 6);
            fill(n, 3'($urandom_range(0, 7)));
            for (int i = 0; i < n; i++) begin
                pa[i] = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
                pb[i] = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
                if (i > 0 && $urandom_range(0, 3) == 0) po[i] = 3'($urandom_range(0, 7));
            end
            send_pkt(n);
            tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rand_valid[%0d]: got %0b want 1", p, out_valid); end
            tests++; if (out_c !== model_c(n)) begin fails++; $display("FAIL rand_c[%0d] op=%0d n=%0d: got %0b want %0b", p, po[0], n, out_c, model_c(n)); end
            tests++; if (out_beats !== model_beats(n)) begin fails++; $display("FAIL rand_beats[%0d]: got %0d want %0d", p, out_beats, model_beats(n)); end
`ifdef LOGICAL_OP_CHECK_EN
            tests++; if (out_err !== model_err(n)) begin fails++; $display("FAIL rand_err[%0d]: got %0b want %0b", p, out_err, model_err(n)); end
`endif
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        @(negedge clk);
    endtask

`ifdef LOGICAL_OP_CHECK_EN
    task automatic test_err();
        fill(2, 3'd7);
        pa[0] = 8'h01; pb[1] = 8'h03;
        send_pkt(2);
        tests++; if (out_err !== 1'b1) begin fails++; $display("FAIL err_op7: got %0b want 1", out_err); end
        tests++; if (out_c !== 1'b1) begin fails++; $display("FAIL err_op7_c: got %0b want 1", out_c); end
        fill(2, 3'd1);
        po[1] = 3'd0; pb[1] = 8'h01;
        send_pkt(2);
        tests++; if (out_err !== 1'b1) begin fails++; $display("FAIL err_chg: got %0b want 1", out_err); end
        tests++; if (out_c !== 1'b1) begin fails++; $display("FAIL err_chg_c: got %0b want 1", out_c); end
        fill(2, 3'd5);
        send_pkt(2);
        tests++; if (out_err !== 1'b0) begin fails++; $display("FAIL err_legal: got %0b want 0", out_err); end
        tests++; if (out_c !== 1'b1) begin fails++; $display("FAIL err_legal_c: got %0b want 1", out_c); end
        @(negedge clk);
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_multi();
        test_backpressure();
        test_saturation();
        test_random();
`ifdef LOGICAL_OP_CHECK_EN
        test_err();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", fails);
        $fatal(1);
    end

endmodule
